intdecl_emit: RTL

Transmit-side counterpart of the team's int-declaration checker: turns a stream of identifier characters into a well-formed ASCII C declaration such as `int a, b_1;`, one byte per handshake. It sits between an identifier source (host FSM or ROM walker) and any byte consumer, including the checker itself for loop-back testing. Identifier lexing rules match the checker: first char letter or `_`, then letters/digits/`_`.

---
 rtl/intdecl_emit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/intdecl_emit.sv
// Emits an ASCII C declaration "int id, id;" one byte per handshake from a stream
// of identifier characters, flagging lexing errors and dropping the rest of a bad declaration.
module intdecl_emit #(
  parameter int MAX_LEN   = 8,
  parameter int SEP_SPACE = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       id_valid_i,
  input  logic [7:0] id_char_i,
  input  logic       id_last_i,
  input  logic       id_end_i,
  output logic       id_ready_o,
  output logic       out_valid_o,
  output logic [7:0] out_char_o,
  input  logic       out_ready_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int CW = $clog2(MAX_LEN + 1);

  typedef enum logic [3:0] {
    IDLE, KW_I, KW_N, KW_T, KW_SP, ID, SEP_C, SEP_S, DRAIN, SEMI, FIN
  } state_e;

  state_e        state_q;
  logic          out_valid_q;
  logic [7:0]    out_char_q;
  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic          done_q;

  logic slot_free;
  logic id_acc;
  logic char_ok;

  function automatic logic is_alpha(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A)) || (c == 8'h5F);
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  assign slot_free  = !out_valid_q || out_ready_i;
  assign id_ready_o = ((state_q == ID) && slot_free) || (state_q == DRAIN);
  assign id_acc     = id_valid_i && id_ready_o;
  assign char_ok    = (cnt_q < CW'(MAX_LEN)) &&
                      (is_alpha(id_char_i) || ((cnt_q != '0) && is_digit(id_char_i)));

  assign out_valid_o = out_valid_q;
  assign out_char_o  = out_char_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;

  // Declaration sequencer and single-entry output stage; a load overrides the drain-on-accept default.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_char_q  <= 8'h00;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (out_valid_q && out_ready_i) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        // 'i' is loaded on the start edge itself so it is valid the very next cycle.
        IDLE: begin
          if (start_i) begin
            err_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            out_char_q  <= 8'h69;
            state_q     <= KW_N;
          end
        end
        KW_I: begin
          if (slot_free) begin
            out_valid_q <= 1'b1;
            out_char_q  <= 8'h69;
            state_q     <= KW_N;
          end
        end
        KW_N: begin
          if (slot_free) begin
            out_valid_q <= 1'b1;
            out_char_q  <= 8'h6E;
            state_q     <= KW_T;
          end
        end
        KW_T: begin
          if (slot_free) begin
            out_valid_q <= 1'b1;
            out_char_q  <= 8'h74;
            state_q     <= KW_SP;
          end
        end
        KW_SP: begin
          if (slot_free) begin
            out_valid_q <= 1'b1;
            out_char_q  <= 8'h20;
            state_q     <= ID;
          end
        end
        ID: begin
          if (id_acc) begin
            if (char_ok) begin
              out_valid_q <= 1'b1;
              out_char_q  <= id_char_i;
              cnt_q       <= id_last_i ? '0 : cnt_q + CW'(1);
              if (id_last_i) begin
                state_q <= id_end_i ? SEMI : SEP_C;
              end
            end else begin
              err_q   <= 1'b1;
              cnt_q   <= '0;
              state_q <= (id_last_i && id_end_i) ? SEMI : DRAIN;
            end
          end
        end
        SEP_C: begin
          if (slot_free) begin
            out_valid_q <= 1'b1;
            out_char_q  <= 8'h2C;
            state_q     <= (SEP_SPACE != 0) ? SEP_S : ID;
          end
        end
        SEP_S: begin
          if (slot_free) begin
            out_valid_q <= 1'b1;
            out_char_q  <= 8'h20;
            state_q     <= ID;
          end
        end
        // Swallow the rest of a bad declaration up to its final character.
        DRAIN: begin
          if (id_acc && id_last_i && id_end_i) begin
            state_q <= SEMI;
          end
        end
        SEMI: begin
          if (slot_free) begin
            out_valid_q <= 1'b1;
            out_char_q  <= 8'h3B;
            state_q     <= FIN;
          end
        end
        FIN: begin
          if (out_valid_q && out_ready_i) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
